// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and helpers for the hazard/forwarding controller.
// Selected by HAZARD_FWD_EN (forwarding) or interlock-only when undefined.
package pipe_pkg;

  localparam int FWD_NONE = 0;

  function automatic int sel_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-side bundle of the hazard unit: operand info in, control out.
// master = pipeline/ID side, slave = hazard unit.
interface pipe_hazard_unit_if
  import pipe_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);

  localparam int SEL_W = sel_w(DEPTH);

  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_we;
  logic                      id_load;
  logic                      ex_br_taken;
  logic                      stall;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_valid, id_src, id_src_used,
    output id_dst, id_we, id_load, ex_br_taken,
    input  stall, flush, fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_used,
    input  id_dst, id_we, id_load, ex_br_taken,
    output stall, flush, fwd_sel, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_unit_src_match.sv
// One ID source operand compared against every in-flight writer;
// reports the youngest matching stage and whether its data is ready.
module hazard_src_match
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 2
) (
  input  logic [REG_AW-1:0]       src,
  input  logic                    used,
  input  logic [DEPTH-1:0]        ent_v,
  input  logic [DEPTH*REG_AW-1:0] ent_dst,
  input  logic [DEPTH-1:0]        ent_rdyz,
  output logic                    hit,
  output logic [SEL_W-1:0]        k,
  output logic                    rdy_zero
);

  // Scan oldest to youngest so the lowest stage overrides.
  always_comb begin
    hit      = 1'b0;
    k        = SEL_W'(FWD_NONE);
    rdy_zero = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_v[i] && used && (src != '0) &&
          (ent_dst[i*REG_AW +: REG_AW] == src)) begin
        hit      = 1'b1;
        k        = SEL_W'(i + 1);
        rdy_zero = ent_rdyz[i];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller beside ID: writer tracking, stall, flush.
// HAZARD_FWD_EN selects forwarding; undefined gives interlock-only.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int NUM_SRC  = 2,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_unit_if.slave  hz
);

  localparam int SEL_W = sel_w(DEPTH);
  localparam int RDY_W = sel_w(DEPTH);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
    logic [RDY_W-1:0]  rdy;
  } entry_t;

  entry_t [DEPTH-1:0] ent;
  logic   [CNT_W-1:0] cnt;

  logic [DEPTH-1:0]         ent_v;
  logic [DEPTH*REG_AW-1:0]  ent_dst;
  logic [DEPTH-1:0]         ent_rdyz;
  logic [NUM_SRC-1:0]       hit;
  logic [NUM_SRC-1:0]       rz;
  logic [NUM_SRC*SEL_W-1:0] kk;
  logic [NUM_SRC-1:0]       req;
  logic [NUM_SRC*SEL_W-1:0] fwd;
  logic                     stall;
  logic                     flush;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_v[i]                    = ent[i].v;
      ent_dst[i*REG_AW +: REG_AW] = ent[i].dst;
      ent_rdyz[i]                 = (ent[i].rdy == '0);
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    hazard_src_match #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_match (
      .src      (hz.id_src[g*REG_AW +: REG_AW]),
      .used     (hz.id_src_used[g]),
      .ent_v    (ent_v),
      .ent_dst  (ent_dst),
      .ent_rdyz (ent_rdyz),
      .hit      (hit[g]),
      .k        (kk[g*SEL_W +: SEL_W]),
      .rdy_zero (rz[g])
    );
  end

  // Stage DEPTH writes the register file first, so it never stalls.
  always_comb begin
    req = '0;
    fwd = '0;
    for (int g = 0; g < NUM_SRC; g++) begin
`ifdef HAZARD_FWD_EN
      req[g] = hit[g] && !rz[g] &&
               (kk[g*SEL_W +: SEL_W] != SEL_W'(DEPTH));
      if (hit[g] && (rz[g] ||
          (kk[g*SEL_W +: SEL_W] == SEL_W'(DEPTH))))
        fwd[g*SEL_W +: SEL_W] = kk[g*SEL_W +: SEL_W];
`else
      req[g] = hit[g] &&
               (kk[g*SEL_W +: SEL_W] != SEL_W'(DEPTH));
`endif
    end
  end

`ifndef HAZARD_FWD_EN
  logic rz_unused;
  assign rz_unused = ^rz;
`endif

  assign flush = hz.ex_br_taken;
  assign stall = (|req) && hz.id_valid && !hz.ex_br_taken;

  assign hz.stall     = stall;
  assign hz.flush     = flush;
  assign hz.fwd_sel   = fwd;
  assign hz.stall_cnt = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent <= '0;
      cnt <= '0;
    end else begin
      ent[0].v   <= hz.id_valid && hz.id_we && !stall && !flush;
      ent[0].dst <= hz.id_dst;
      ent[0].rdy <= hz.id_load ? RDY_W'(LOAD_LAT) : '0;
      for (int i = 1; i < DEPTH; i++) begin
        ent[i].v   <= ent[i-1].v;
        ent[i].dst <= ent[i-1].dst;
        ent[i].rdy <= (ent[i-1].rdy == '0) ? '0
                                           : ent[i-1].rdy - 1'b1;
      end
      if (stall && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

endmodule
